// File: rtl/counter_timer_arbiter.sv
// Counter-timer arbiter: shares one oneshot down-counting timer among four
// requesters. Each run writes the reset value, starts the timer, waits for
// the stop flag (or a withdrawn request), disables the timer and reports
// completion to the owner. Owners are picked round-robin.
//
// Handshake: req_i[k] is a level request that stays high until done_o[k]
// pulses (completed run) or until the requester drops it (abort). Dropping
// the request while the timer is being armed or running stops the run
// early and produces no done_o pulse.
module counter_timer_arbiter #(
  parameter bit IRQ_ENA = 1'b0
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [3:0]   req_i,
  input  logic [127:0] req_val_i,
  output logic [3:0]   grant_o,
  output logic [3:0]   done_o,
  output logic         busy_o,
  output logic [3:0]   timer_val_we_o,
  output logic [31:0]  timer_val_do_o,
  output logic         timer_cfg_we_o,
  output logic [31:0]  timer_cfg_do_o,
  input  logic         timer_stop_i,
  output logic [2:0]   dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_ARM1  = 3'd3,
    S_ARM2  = 3'd4,
    S_RUN   = 3'd5,
    S_STOP  = 3'd6,
    S_DONE  = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [31:0] val_q, val_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        abort_q, abort_d;

  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        win_vld;
  logic        owner_req;
  logic [3:0]  owner_oh;

  assign owner_req   = req_i[owner_q];
  assign owner_oh    = 4'b0001 << owner_q;
  assign dbg_state_o = state_q;

  // Round-robin pick: first set request at or after the pointer, cyclically.
  // Scanning from the farthest offset down lets the nearest one win.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    cand    = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req_i[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state logic; abort_q remembers whether the run ended by withdrawal.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    val_d   = val_q;
    ptr_d   = ptr_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          val_d   = req_val_i[{win_idx, 5'd0} +: 32];
          abort_d = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_START;
      S_START: begin
        if (!owner_req) begin
          abort_d = 1'b1;
          state_d = S_STOP;
        end else begin
          state_d = S_ARM1;
        end
      end
      // The stop flag may still be set from the previous run while the
      // restarted timer settles, so only the request is watched here.
      S_ARM1: begin
        if (!owner_req) begin
          abort_d = 1'b1;
          state_d = S_STOP;
        end else begin
          state_d = S_ARM2;
        end
      end
      S_ARM2: begin
        if (!owner_req) begin
          abort_d = 1'b1;
          state_d = S_STOP;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!owner_req) begin
          abort_d = 1'b1;
          state_d = S_STOP;
        end else if (timer_stop_i) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        ptr_d   = owner_q + 2'd1;
        state_d = abort_q ? S_IDLE : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and run-context registers; reset abandons any run in flight.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      owner_q <= 2'd0;
      val_q   <= 32'd0;
      ptr_q   <= 2'd0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      val_q   <= val_d;
      ptr_q   <= ptr_d;
      abort_q <= abort_d;
    end
  end

  // Outputs decode from the registered state only, so reset clears them
  // without waiting for a clock.
  always_comb begin
    busy_o         = (state_q != S_IDLE);
    grant_o        = busy_o ? owner_oh : 4'd0;
    done_o         = (state_q == S_DONE) ? owner_oh : 4'd0;
    timer_val_we_o = 4'd0;
    timer_val_do_o = 32'd0;
    timer_cfg_we_o = 1'b0;
    timer_cfg_do_o = 32'd0;
    case (state_q)
      S_LOAD: begin
        timer_val_we_o = 4'hF;
        timer_val_do_o = val_q;
      end
      S_START: begin
        timer_cfg_we_o = 1'b1;
        timer_cfg_do_o = {27'd0, IRQ_ENA, 1'b0, 1'b0, 1'b1, 1'b1};
      end
      S_STOP: begin
        timer_cfg_we_o = 1'b1;
        timer_cfg_do_o = 32'd0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_timer_arbiter.sv
// Bench for counter_timer_arbiter: directed scenarios plus randomized
// requesters, with a behavioural timer and a timeline reference model.
module tb_counter_timer_arbiter;

  localparam bit TB_IRQ = 1'b1;
  localparam int W      = 96;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req = 4'd0;
  logic [127:0] req_val = '0;
  logic         timer_stop = 1'b0;
  logic [3:0]   grant, done, val_we;
  logic         busy, cfg_we;
  logic [31:0]  val_do, cfg_do;
  logic [2:0]   dbg_state;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];
  bit stale_en = 1'b0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  counter_timer_arbiter #(.IRQ_ENA(TB_IRQ)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .req_i          (req),
    .req_val_i      (req_val),
    .grant_o        (grant),
    .done_o         (done),
    .busy_o         (busy),
    .timer_val_we_o (val_we),
    .timer_val_do_o (val_do),
    .timer_cfg_we_o (cfg_we),
    .timer_cfg_do_o (cfg_do),
    .timer_stop_i   (timer_stop),
    .dbg_state_o    (dbg_state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [3:0] oh(int k);
    return 4'b0001 << k;
  endfunction

  function automatic logic [W-1:0] mk_rec(int c, logic [3:0] vwe, logic cwe,
                                          logic [3:0] dn, logic [3:0] gr,
                                          logic [31:0] vdo, logic [31:0] cdo);
    logic [15:0] c16;
    c16 = c[15:0];
    return {c16, vwe, cwe, dn, gr, 3'b000, vdo, cdo};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, expv);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s timeout at cyc=%0d actual=no-event required=event", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- timer plant ----------------
  // Oneshot down-counter: stop rises max(V,1)+2 cycles after the start
  // write. With stale_en the flag from the previous run lingers until the
  // restarted timer has settled (three cycles after the start write).
  logic [31:0] t_val = '0;
  bit  t_run = 1'b0;
  bit  t_keep = 1'b0;
  int  t_off = 0;
  always @(negedge clk) begin
    if (rst) begin
      timer_stop = 1'b0;
      t_run = 1'b0;
    end else begin
      if (val_we == 4'hF) t_val = val_do;
      if (cfg_we && cfg_do[0]) begin
        t_run  = 1'b1;
        t_off  = 0;
        t_keep = stale_en & timer_stop;
      end else if (cfg_we && !cfg_do[0]) begin
        t_run = 1'b0;
        if (!stale_en) timer_stop = 1'b0;
      end else if (t_run) begin
        t_off++;
      end
      if (t_run)
        timer_stop = (longint'(t_off) >= ((t_val == 0) ? 64'd1 : longint'(t_val)) + 2)
                     || (t_off < 3 && t_keep);
    end
  end

  // ---------------- reference model ----------------
  // A run granted on cycle t loads at t+1, starts at t+2 and sees the stop
  // at t+max(V,1)+4; a withdrawn request from t+2 on stops it one cycle
  // later without completion.
  bit          m_busy = 1'b0;
  bit          m_decided = 1'b0;
  int          m_owner = 0;
  int          m_ptr = 0;
  int          m_t = 0;
  int          m_free = 0;
  longint      m_seen = 0;
  logic [31:0] m_val;
  logic [31:0] cfg_start;
  assign cfg_start = {27'd0, TB_IRQ, 4'b0011};

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      exp_q.delete();
    end else begin
      if (m_busy && m_decided && cyc == m_free) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 4;
      end
      check("grant_busy", {grant, busy}, m_busy ? {oh(m_owner), 1'b1} : 5'd0);
      if (m_busy && !m_decided && cyc >= m_t + 2) begin
        if (!req[m_owner]) begin
          exp_q.push_back(mk_rec(cyc + 1, 4'd0, 1'b1, 4'd0, oh(m_owner), 32'd0, 32'd0));
          m_free = cyc + 2;
          m_decided = 1'b1;
        end else if (longint'(cyc) == m_seen) begin
          exp_q.push_back(mk_rec(cyc + 1, 4'd0, 1'b1, 4'd0, oh(m_owner), 32'd0, 32'd0));
          exp_q.push_back(mk_rec(cyc + 2, 4'd0, 1'b0, oh(m_owner), oh(m_owner), 32'd0, 32'd0));
          m_free = cyc + 3;
          m_decided = 1'b1;
        end
      end
      if (!m_busy && req != 4'd0) begin
        for (int k = 3; k >= 0; k--)
          if (req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        m_val  = req_val[32*m_owner +: 32];
        m_t    = cyc;
        m_seen = longint'(cyc) + ((m_val == 0) ? 64'd1 : longint'(m_val)) + 4;
        exp_q.push_back(mk_rec(cyc + 1, 4'hF, 1'b0, 4'd0, oh(m_owner), m_val, 32'd0));
        exp_q.push_back(mk_rec(cyc + 2, 4'd0, 1'b1, 4'd0, oh(m_owner), 32'd0, cfg_start));
        m_busy = 1'b1;
        m_decided = 1'b0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (val_we != 4'd0 || cfg_we || done != 4'd0) begin
        if (exp_q.size() == 0)
          check("unexpected_strobe",
                mk_rec(cyc, val_we, cfg_we, done, grant, val_do, cfg_do), '0);
        else
          check("strobe", mk_rec(cyc, val_we, cfg_we, done, grant, val_do, cfg_do),
                exp_q.pop_front());
      end else begin
        check("quiet_data", {val_do, cfg_do}, '0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic serve_all(input string name);
    int i;
    for (i = 0; i < 300; i++) begin
      tick();
      for (int k = 0; k < 4; k++) if (done[k]) req[k] = 1'b0;
      if (req == 4'd0 && !busy) break;
    end
    if (i == 300) timeout_fail(name);
  endtask

  task automatic run_single(input int k, input logic [31:0] v, input int lat, input string name);
    int t;
    int i;
    tick();
    req_val[32*k +: 32] = v;
    req[k] = 1'b1;
    t = cyc;
    for (i = 0; i < 40; i++) begin
      tick();
      if (done[k]) begin
        check(name, cyc - t, lat);
        req[k] = 1'b0;
        break;
      end
    end
    if (i == 40) timeout_fail(name);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (i % 50 == 0) stale_en = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        if (req[k]) begin
          if (done[k]) begin
            if ($urandom_range(0, 3) != 0) req[k] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) begin
            req[k] = 1'b0;
          end else if ($urandom_range(0, 7) == 0) begin
            req_val[32*k +: 32] = $urandom_range(0, 6);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req_val[32*k +: 32] = $urandom_range(0, 6);
          req[k] = 1'b1;
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    int last;
    int n;
    int i;
    logic [3:0] order_exp [5];
    order_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (3) @(negedge clk);
    check("reset_outputs", {grant, done, busy, val_we, val_do, cfg_we, cfg_do}, '0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Single request, value 5: done 11 cycles after the sampling cycle.
    run_single(0, 32'd5, 11, "latency_v5");
    // Value 0 on requester 3: done 7 cycles later; pointer wraps to 0.
    run_single(3, 32'd0, 7, "latency_v0");

    // Round robin with all four held and a lingering stop flag.
    stale_en = 1'b1;
    tick();
    req_val = {4{32'd2}};
    req = 4'hF;
    t = cyc;
    last = t;
    n = 0;
    for (i = 0; i < 80 && n < 5; i++) begin
      tick();
      if (done != 4'd0) begin
        check("rr_order", done, order_exp[n]);
        check("rr_spacing", cyc - last, (n == 0) ? 8 : 9);
        last = cyc;
        n++;
      end
    end
    if (n < 5) timeout_fail("rr_done");
    req = 4'd0;
    stale_en = 1'b0;

    // Abort: requester 2 withdraws in RUN, requester 3 is served next.
    tick();
    tick();
    req_val[64 +: 32] = 32'd6;
    req[2] = 1'b1;
    tick();
    req_val[96 +: 32] = 32'd1;
    req_val[0 +: 32]  = 32'd1;
    req[3] = 1'b1;
    req[0] = 1'b1;
    repeat (5) tick();
    req[2] = 1'b0;
    repeat (3) tick();
    check("abort_next_grant", grant, 4'b1000);
    serve_all("abort_drain");

    // Randomized requesters.
    rand_phase(700);
    req = 4'd0;
    serve_all("rand_drain");
    stale_en = 1'b0;

    // Move the pointer off zero, then start a maximum-length run and reset it.
    run_single(1, 32'd1, 7, "latency_v1");
    tick();
    req_val[64 +: 32] = 32'hFFFF_FFFF;
    req[2] = 1'b1;
    repeat (6) tick();
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = 4'd0;
    #1;
    check("async_reset", {grant, done, busy, val_we, val_do, cfg_we, cfg_do}, '0);
    @(negedge clk);
    check("reset_hold", {grant, done, busy, val_we, val_do, cfg_we, cfg_do}, '0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    req_val = {4{32'd1}};
    req = 4'hF;
    tick();
    check("post_reset_grant", grant, 4'b0001);
    serve_all("post_reset_drain");

    repeat (4) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
